// File: rtl/counter_cmd_seq_pkg.sv
// Shared types and default widths for the counter command sequencer.
package counter_cmd_pkg;

  localparam int unsigned DefDw    = 4;
  localparam int unsigned DefLw    = 4;
  localparam int unsigned DefDepth = 4;

  typedef enum logic [1:0] {
    OpLoad = 2'b00,
    OpUp   = 2'b01,
    OpDown = 2'b10,
    OpNop  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StNop
  } seq_state_e;

  typedef struct packed {
    cmd_op_e            op;
    logic [DefDw-1:0]   arg;
    logic [DefLw-1:0]   len;
  } cmd_t;

endpackage

// File: rtl/counter_cmd_seq_if.sv
// Command valid/ready channel into the sequencer.
interface counter_cmd_seq_if #(
  parameter int unsigned DW = 4,
  parameter int unsigned LW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_arg;
  logic [LW-1:0] cmd_len;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, output cmd_len,
                  input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, input cmd_len,
                  output cmd_ready);
endinterface

// File: rtl/counter_cmd_seq_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so pointers wrap naturally.
module cmd_fifo
  import counter_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t wdata,
  input  logic pop,
  output logic full,
  output logic empty,
  output cmd_t head
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  cmd_t            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/counter_cmd_seq.sv
// Turns queued LOAD/UP/DOWN/NOP commands into per-cycle load/data/updown drive for
// a 4-bit up/down counter, chaining commands with no idle gap.
module counter_cmd_seq
  import counter_cmd_pkg::*;
#(
  parameter int unsigned DW    = DefDw,
  parameter int unsigned LW    = DefLw,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic             clk,
  input  logic             rst,
  counter_cmd_seq_if.slave cmd,
  output logic             load,
  output logic [DW-1:0]    data,
  output logic             updown,
  output logic             busy,
  output logic             done
);

  seq_state_e    state_q, state_d;
  logic [LW-1:0] remain_q, remain_d;
  logic          load_q, load_d;
  logic [DW-1:0] data_q, data_d;
  logic          updown_q, updown_d;
  logic          done_q, done_d;

  cmd_t wdata, head;
  logic full, empty, push, pop, last_beat;

  assign wdata.op  = cmd_op_e'(cmd.cmd_op);
  assign wdata.arg = cmd.cmd_arg;
  assign wdata.len = cmd.cmd_len;

  assign cmd.cmd_ready = !full;
  assign push          = cmd.cmd_valid && !full;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign last_beat = (state_q == StLoad) || (state_q == StNop) ||
                     ((state_q == StRun) && (remain_q == '0));
  assign pop       = !empty && ((state_q == StIdle) || last_beat);

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    load_d   = 1'b0;
    data_d   = data_q;
    updown_d = updown_q;
    done_d   = 1'b0;
    if (pop) begin
      unique case (head.op)
        OpLoad: begin
          state_d = StLoad;
          load_d  = 1'b1;
          data_d  = head.arg;
          done_d  = 1'b1;
        end
        OpUp, OpDown: begin
          state_d  = StRun;
          remain_d = head.len;
          updown_d = (head.op == OpUp);
          done_d   = (head.len == '0);
        end
        default: begin
          state_d = StNop;
          done_d  = 1'b1;
        end
      endcase
    end else if ((state_q == StRun) && !last_beat) begin
      remain_d = remain_q - LW'(1);
      // done is registered, so it is raised while entering the final beat
      done_d   = (remain_q == LW'(1));
    end else begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      remain_q <= '0;
      load_q   <= 1'b0;
      data_q   <= '0;
      updown_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      load_q   <= load_d;
      data_q   <= data_d;
      updown_q <= updown_d;
      done_q   <= done_d;
    end
  end

  assign load   = load_q;
  assign data   = data_q;
  assign updown = updown_q;
  assign done   = done_q;
  assign busy   = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, and random
// traffic compared every cycle against a per-command beat-list reference model.
module tb_counter_cmd_seq;

  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       load, updown, busy, done;
  logic [3:0] data;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  counter_cmd_seq_if #(.DW(4), .LW(4)) ifc ();

  counter_cmd_seq #(.DW(4), .LW(4), .DEPTH(Depth)) dut (
    .clk    (clk),
    .rst    (rst),
    .cmd    (ifc),
    .load   (load),
    .data   (data),
    .updown (updown),
    .busy   (busy),
    .done   (done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference model: FIFO of commands plus the list of output beats still to present.
  typedef struct packed {
    logic [1:0] op;
    logic [3:0] arg;
    logic [3:0] len;
  } mcmd_t;

  typedef struct packed {
    logic       load;
    logic [3:0] data;
    logic       ud;
    logic       done;
  } beat_t;

  mcmd_t      pend[$];
  beat_t      cur[$];
  logic       m_ud = 1'b1;
  logic [3:0] m_data = 4'h0;

  task automatic expand(input mcmd_t c);
    beat_t b;
    case (c.op)
      2'b00: begin
        m_data = c.arg;
        b = '{load: 1'b1, data: c.arg, ud: m_ud, done: 1'b1};
        cur.push_back(b);
      end
      2'b01, 2'b10: begin
        m_ud = (c.op == 2'b01);
        for (int i = 0; i <= int'(c.len); i++) begin
          b = '{load: 1'b0, data: m_data, ud: m_ud, done: (i == int'(c.len))};
          cur.push_back(b);
        end
      end
      default: begin
        b = '{load: 1'b0, data: m_data, ud: m_ud, done: 1'b1};
        cur.push_back(b);
      end
    endcase
  endtask

  initial begin
    logic  do_push;
    mcmd_t c;
    forever begin
      @(posedge clk);
      if (rst) begin
        pend.delete();
        cur.delete();
        m_ud   = 1'b1;
        m_data = 4'h0;
      end else begin
        do_push = ifc.cmd_valid && (pend.size() < Depth);
        if (cur.size() <= 1 && pend.size() > 0) begin
          c = pend.pop_front();
          cur.delete();
          expand(c);
        end else if (cur.size() > 0) begin
          void'(cur.pop_front());
        end
        if (do_push) pend.push_back({ifc.cmd_op, ifc.cmd_arg, ifc.cmd_len});
      end
    end
  end

  initial begin
    beat_t      b;
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (cur.size() > 0) b = cur[0];
        else b = '{load: 1'b0, data: m_data, ud: m_ud, done: 1'b0};
        exp = {b.load, b.data, b.ud, b.done, (cur.size() > 0 || pend.size() > 0),
               (pend.size() < Depth)};
        check("model", {load, data, updown, done, busy, ifc.cmd_ready}, 32'(exp));
      end
    end
  end

  // The attached 4-bit counter, fed by the DUT outputs.
  logic [3:0] cnt = 4'h0;
  initial begin
    forever begin
      @(posedge clk);
      if (rst) cnt = 4'h0;
      else if (load) cnt = data;
      else cnt = updown ? cnt + 4'd1 : cnt - 4'd1;
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [1:0] op, input logic [3:0] arg, input logic [3:0] len);
    int k = 0;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_arg   = arg;
    ifc.cmd_len   = len;
    while (!ifc.cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("send_ready", 32'(ifc.cmd_ready), 32'd1);
    @(posedge clk);
    #1 ifc.cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] arg;
    logic [3:0] len;
    int         exp_cycles;
    logic       exp_ud;
    logic [3:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int         cycles;
    logic [3:0] cnt0, exp_cnt, seen;
    logic [3:0] chain_exp[6];

    vecs[0] = '{op: 2'b00, arg: 4'h9, len: 4'h0, exp_cycles: 1,  exp_ud: 1'b1, exp_data: 4'h9};
    vecs[1] = '{op: 2'b01, arg: 4'h0, len: 4'h3, exp_cycles: 4,  exp_ud: 1'b1, exp_data: 4'h9};
    vecs[2] = '{op: 2'b10, arg: 4'h5, len: 4'h0, exp_cycles: 1,  exp_ud: 1'b0, exp_data: 4'h9};
    vecs[3] = '{op: 2'b11, arg: 4'h7, len: 4'h6, exp_cycles: 1,  exp_ud: 1'b0, exp_data: 4'h9};
    vecs[4] = '{op: 2'b01, arg: 4'h0, len: 4'hF, exp_cycles: 16, exp_ud: 1'b1, exp_data: 4'h9};
    vecs[5] = '{op: 2'b00, arg: 4'h3, len: 4'h7, exp_cycles: 1,  exp_ud: 1'b1, exp_data: 4'h3};
    vecs[6] = '{op: 2'b11, arg: 4'h0, len: 4'h0, exp_cycles: 1,  exp_ud: 1'b1, exp_data: 4'h3};
    vecs[7] = '{op: 2'b10, arg: 4'hA, len: 4'h5, exp_cycles: 6,  exp_ud: 1'b0, exp_data: 4'h3};
    chain_exp[0] = 4'h2; chain_exp[1] = 4'h1; chain_exp[2] = 4'h0;
    chain_exp[3] = 4'hF; chain_exp[4] = 4'hE; chain_exp[5] = 4'hF;

    rst = 1'b1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op = 2'b00;
    ifc.cmd_arg = 4'h0;
    ifc.cmd_len = 4'h0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_state", 32'({load, data, updown, done, busy, ifc.cmd_ready}), 32'b0_0000_1_0_0_1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      wait_idle();
      send(vecs[i].op, vecs[i].arg, vecs[i].len);
      check("lat_busy", 32'(busy), 32'd1);
      check("lat_noload", 32'(load), 32'd0);
      @(negedge clk);
      cnt0 = cnt;
      cycles = 1;
      while (!done && cycles < 40) begin
        @(negedge clk);
        cycles++;
      end
      check("vec_cycles", 32'(cycles), 32'(vecs[i].exp_cycles));
      check("vec_updown", 32'(updown), 32'(vecs[i].exp_ud));
      check("vec_data", 32'(data), 32'(vecs[i].exp_data));
      case (vecs[i].op)
        2'b00:   exp_cnt = vecs[i].arg;
        2'b01:   exp_cnt = cnt0 + 4'(vecs[i].exp_cycles);
        2'b10:   exp_cnt = cnt0 - 4'(vecs[i].exp_cycles);
        default: exp_cnt = vecs[i].exp_ud ? cnt0 + 4'd1 : cnt0 - 4'd1;
      endcase
      @(negedge clk);
      check("vec_counter", 32'(cnt), 32'(exp_cnt));
      check("vec_busy_fall", 32'(busy), 32'd0);
    end

    // LOAD 9 chained with UP len=3 lands the counter on 13.
    wait_idle();
    send(2'b00, 4'h9, 4'h0);
    send(2'b01, 4'h0, 4'h3);
    repeat (5) @(negedge clk);
    check("up_run_counter", 32'(cnt), 32'd13);

    // Back-to-back chaining, no idle gap.
    wait_idle();
    send(2'b00, 4'h2, 4'h0);
    send(2'b10, 4'h0, 4'h3);
    send(2'b00, 4'hF, 4'h0);
    for (int i = 0; i < 6; i++) begin
      check("chain_counter", 32'(cnt), 32'(chain_exp[i]));
      @(negedge clk);
    end

    // FIFO full: one command in the FSM plus DEPTH queued.
    wait_idle();
    send(2'b01, 4'h0, 4'hF);
    for (int i = 0; i < 4; i++) send(2'b11, 4'h0, 4'h0);
    check("full_ready_low", 32'(ifc.cmd_ready), 32'd0);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op = 2'b00;
    ifc.cmd_arg = 4'h5;
    seen = 4'h0;
    cycles = 0;
    while (!ifc.cmd_ready && cycles < 40) begin
      seen = {3'b000, done};
      @(negedge clk);
      cycles++;
    end
    check("full_release_after_done", 32'(seen), 32'd1);
    @(posedge clk);
    #1 ifc.cmd_valid = 1'b0;
    @(negedge clk);
    wait_idle();

    // Reset on the 6th beat of a long UP run with two commands queued.
    send(2'b01, 4'h0, 4'hF);
    send(2'b00, 4'h1, 4'h0);
    send(2'b11, 4'h0, 4'h0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_values", 32'({load, data, updown, done, busy, ifc.cmd_ready}),
          32'b0_0000_1_0_0_1);
    rst = 1'b0;
    seen = 4'h0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | {2'b00, done, busy};
    end
    check("mid_reset_no_residual", 32'(seen), 32'd0);

    // Random traffic, including occasional resets, against the model.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      ifc.cmd_valid = 1'($urandom_range(0, 1));
      ifc.cmd_op = 2'($urandom_range(0, 3));
      ifc.cmd_arg = 4'($urandom_range(0, 15));
      ifc.cmd_len = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      @(negedge clk);
    end
    rst = 1'b0;
    ifc.cmd_valid = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_cmd_seq.md
# counter_cmd_seq

Command sequencer sitting directly upstream of the 4-bit up/down counter. It accepts high-level commands (load value, count up N cycles, count down N cycles, no-op) over a valid/ready handshake. Commands are buffered in a small FIFO and turned into the per-cycle `load` / `data` / `updown` drive the counter needs. The counter counts on every non-load cycle, so this block always drives a defined direction, including when idle.

## Interface
Parameters:
- `DW`, 4: data width; must match the counter width.
- `LW`, 4: width of the command length field.
- `DEPTH`, 4: command FIFO depth; power of two, ≥2.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: FIFO can accept; equals `!full`, combinational from FIFO count.
- `cmd_op`, in, 2: 00 LOAD, 01 UP, 10 DOWN, 11 NOP.
- `cmd_arg`, in, DW: load value; ignored for UP, DOWN and NOP.
- `cmd_len`, in, LW: UP/DOWN run length minus 1; ignored for LOAD and NOP.
- `load`, out, 1: to counter `load`; registered.
- `data`, out, DW: to counter `data`; registered.
- `updown`, out, 1: to counter `updown`; 1 means up; registered.
- `busy`, out, 1: FSM not IDLE, or FIFO non-empty.
- `done`, out, 1: one-cycle pulse, coincident with the last output cycle of each command.

## Operation
- Handshake: a command is written on a rising edge where `cmd_valid && cmd_ready`. `cmd_valid` may be held or dropped freely; there is no backpressure on the output side.
- FSM states:
  - IDLE: `load`=0; `updown` holds its last value.
  - LOAD: exactly 1 cycle with `load`=1 and `data`=arg.
  - RUN: `cmd_len`+1 cycles with `load`=0 and `updown`=1 (UP) or 0 (DOWN); a 4-bit down-counter tracks the remaining cycles.
  - NOP: exactly 1 cycle with `load`=0 and `updown` unchanged.
- Pop rule: the FSM pops the FIFO head when it is in IDLE, or when it is in the last cycle of LOAD, NOP or RUN (remaining==0), and the FIFO is non-empty. This gives back-to-back commands with no idle gap. If the FIFO is empty at that point, the FSM goes to IDLE.
- `data` updates only on a LOAD pop and otherwise holds its value.
- `done`=1 in the cycle that presents a command's last output cycle.
- FIFO boundaries:
  - Push and pop on the same edge: both happen and the count is unchanged.
  - When full, `cmd_ready`=0, so a simultaneous push-when-full cannot occur.
  - Pop when empty never happens.
  - Pointers wrap modulo DEPTH; the count is DEPTH+1 states wide.
- `cmd_len` = 2^LW-1 gives a 2^LW-cycle run.
- Op 11 is a legal NOP, not an error.

## Timing
- Reset values: `load`=0, `data`=0, `updown`=1, `done`=0, `busy`=0, `cmd_ready`=1; FIFO emptied, FSM in IDLE.
- Latency: a command accepted at edge N, into an empty FIFO with the FSM in IDLE, is popped at edge N+1. Its first output cycle is driven between edges N+1 and N+2, and the counter samples it at edge N+2.
- `busy` goes high in the cycle after the accept edge. It falls in the cycle after the last `done` when no further command is queued.
- Reset mid-operation, on any edge with `rst`=1: all reset values apply at once. Queued and in-flight commands are discarded, with no `done` for them.
- Reset has priority over a simultaneous push; the pushed command is dropped.

## Structure
- Package `counter_cmd_pkg`:
  - `cmd_op_e` enum (LOAD, UP, DOWN, NOP).
  - `seq_state_e` enum (IDLE, LOAD, RUN, NOP).
  - packed struct `cmd_t` {op, arg, len}.
  - Default widths as localparams.
- Sub-module `cmd_fifo`: synchronous FIFO of `cmd_t`, parameterised by DEPTH. Ports: push, pop, full, empty, head. It uses the same clk/rst.
- The top level holds the FSM, the run counter and the output registers.

## Test plan
- Reset then single LOAD: accept {LOAD, arg=9} at edge 1. Then `load`=1 and `data`=9 in cycle 2–3 only, `done`=1 in that cycle, and `busy` back to 0 in cycle 3–4.
- UP run: {UP, len=3} gives `updown`=1 and `load`=0 for exactly 4 cycles with `done` on the 4th. With the counter attached after LOAD 9, the counter reads 13.
- Back-to-back chaining: LOAD 2, DOWN len=3, LOAD 0xF queued together. Required: no idle gap between commands, and the counter sequence 2,1,0,F,E,F.
- FIFO full: push 5 commands without the FSM draining. `cmd_ready`=0 after DEPTH+1 accepted (FIFO 4 plus 1 in the FSM). The extra command is held off and accepted once `done` frees a slot.
- Reset mid-RUN: {UP, len=15} with `rst` asserted on its 6th cycle and 2 commands queued. All outputs take reset values on the next cycle and no `done` pulses. After reset release, `busy`=0 with no residual commands.
- NOP and len wrap: {DOWN, len=0} gives 1 cycle. Then NOP keeps `updown`=0 for 1 cycle with `done`. Then {UP, len=15} gives exactly 16 up cycles.
